paddsb_arbiter: RTL

Two-requester arbiter that time-shares one PADDSB_16b saturating-add datapath (four signed 4-bit lanes per 16-bit word). It grants one request per cycle using round-robin priority, captures the PADDSB_16b result in a single-entry output register, and returns it with the requester's ID over a valid/ready response channel. It sits between the two pipeline clients that issue packed-saturating-add operations and the shared adder.

---
 rtl/paddsb_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/paddsb_arbiter.sv
// -----------------------------------------------------------------------------
// paddsb_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter in front of one shared PADDSB_16b
//   packed saturating adder. The adder works on four signed 4-bit lanes per
//   16-bit word. One request is granted per cycle. The saturated sum and the
//   requester ID are captured in a single-entry output register. The result
//   is returned over a valid/ready response channel.
//
// Optional feature:
//   PADDSB_ARB_SATFLAG_EN - when defined, adds the rsp_sat[3:0] port and its
//   register, holding one saturation flag per lane. When it is undefined, the
//   port and the register are absent and all other behaviour is unchanged.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req0       in   1   requester 0 has an operation pending
//   a0, b0     in  16   requester 0 operands
//   req1       in   1   requester 1 has an operation pending
//   a1, b1     in  16   requester 1 operands
//   gnt0       out  1   combinational; requester 0's operands taken this cycle
//   gnt1       out  1   combinational; requester 1's operands taken this cycle
//   rsp_valid  out  1   output register holds a result
//   rsp_ready  in   1   consumer accepts the held result this cycle
//   rsp_id     out  1   requester that produced the held result
//   rsp_data   out 16   held saturated sum
//   rsp_sat    out  4   per-lane saturation flags (PADDSB_ARB_SATFLAG_EN only)
//
// Handshake: the response transfers on a cycle where rsp_valid & rsp_ready.
// A requester holds reqN and its operands until it sees gntN=1 on a rising
// edge. At that edge its operands are consumed.
// -----------------------------------------------------------------------------

// Packed saturating add: four independent signed 4-bit lanes, no carry between lanes.
module paddsb_16b (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
`ifdef PADDSB_ARB_SATFLAG_EN
    ,
    output logic [3:0]  sat_o
`endif
);
    genvar k;
    for (k = 0; k < 4; k++) begin : g_lane
        logic [3:0] raw;
        logic       a_s;
        logic       b_s;
        logic       ovf;

        assign a_s = a_i[4*k+3];
        assign b_s = b_i[4*k+3];
        assign raw = a_i[4*k +: 4] + b_i[4*k +: 4];
        // Overflow only when both signs agree and the raw sign flips.
        assign ovf = (a_s == b_s) && (raw[3] != a_s);
        assign sum_o[4*k +: 4] = ovf ? (a_s ? 4'h8 : 4'h7) : raw;
`ifdef PADDSB_ARB_SATFLAG_EN
        assign sat_o[k] = ovf;
`endif
    end
endmodule

module paddsb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data
`ifdef PADDSB_ARB_SATFLAG_EN
    ,
    output logic [3:0]  rsp_sat
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        id_q;
    logic [15:0] data_q;

    logic        can_accept;
    logic        grant;
    logic        sel;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] sum;
`ifdef PADDSB_ARB_SATFLAG_EN
    logic [3:0]  sat;
    logic [3:0]  sat_q;
`endif

    // ---------------- arbitration ----------------
    // The single entry can be refilled in the same cycle it drains.
    assign can_accept = (state_q == ST_EMPTY) | rsp_ready;

    // Gating with rst_n keeps grants low while reset is asserted, even though
    // requests may already be pending.
    assign gnt0 = rst_n & can_accept & req0 & (~req1 | (prio_q == 1'b0));
    assign gnt1 = rst_n & can_accept & req1 & (~req0 | (prio_q == 1'b1));
    assign grant = gnt0 | gnt1;
    assign sel   = gnt1;

    // The next grant favours whoever lost this one. prio holds without a grant.
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    // ---------------- shared datapath ----------------
    assign op_a = sel ? a1 : a0;
    assign op_b = sel ? b1 : b0;

    paddsb_16b u_paddsb (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (sum)
`ifdef PADDSB_ARB_SATFLAG_EN
        ,
        .sat_o (sat)
`endif
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !grant) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
    end

    // ---------------- priority pointer and output entry ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            id_q   <= 1'b0;
            data_q <= 16'h0000;
        end else begin
            prio_q <= prio_d;
            if (grant) begin
                id_q   <= sel;
                data_q <= sum;
            end
        end
    end

`ifdef PADDSB_ARB_SATFLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 4'h0;
        end else if (grant) begin
            sat_q <= sat;
        end
    end

    assign rsp_sat = sat_q;
`endif

    assign rsp_id   = id_q;
    assign rsp_data = data_q;

endmodule
